// File: rtl/int_sequencer_if.sv
// Interrupt sequencer bundle: CPU/controller-side inputs and sequencer outputs.
interface int_sequencer_if #(
  parameter int AW = 32
);
  logic          in_break;
  logic [1:0]    in_code;
  logic          in_boundary;
  logic [AW-1:0] in_PC;
  logic          in_eret;
  logic          in_ie_we;
  logic          in_ie_data;
  logic          in_inm_we;
  logic [2:0]    in_inm_data;
  logic          out_IE;
  logic [3:0]    out_INM;
  logic [3:0]    out_IG;
  logic          out_stall;
  logic          out_pc_load;
  logic [AW-1:0] out_pc;
  logic [1:0]    out_level;
  logic          out_err;

  modport master (
    output in_break, in_code, in_boundary, in_PC, in_eret,
           in_ie_we, in_ie_data, in_inm_we, in_inm_data,
    input  out_IE, out_INM, out_IG, out_stall, out_pc_load, out_pc,
           out_level, out_err
  );

  modport slave (
    input  in_break, in_code, in_boundary, in_PC, in_eret,
           in_ie_we, in_ie_data, in_inm_we, in_inm_data,
    output out_IE, out_INM, out_IG, out_stall, out_pc_load, out_pc,
           out_level, out_err
  );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: acks the source, stacks PC/mask/IE, redirects to the vector.
// Latency: take -> out_pc_load in 3 cycles (T0 take, T1 ack, T2 redirect); ERET -> redirect next cycle.
// Backpressure: out_stall holds the CPU from the take/ERET cycle until the sequence returns to IDLE.
module int_sequencer #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] VEC_BASE  = AW'(32'h0000_0100),
  parameter int            VEC_SHIFT = 4,
  parameter int            DEPTH     = 3
) (
  input logic            in_CLK,
  input logic            in_RST,
  int_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACK    = 2'd1;
  localparam logic [1:0] S_VECTOR = 2'd2;
  localparam logic [1:0] S_RET    = 2'd3;
  localparam logic [1:0] LVL_MAX  = 2'(DEPTH);

  logic [1:0]    state;
  logic [1:0]    code_q;
  logic [AW-1:0] pc_q;
  logic [1:0]    level;
  logic [1:0]    top;
  logic          ie_q;
  logic [2:0]    inm_q;
  logic          err_q;
  logic          idle, req, ovf, take, eret, eret_ok, eret_bad, sw_ok;
  logic [2:0]    code_mask;
  logic [3:0]    ig_dec;
  logic [AW-1:0] vec_pc;

  logic [AW-1:0] stk_pc  [DEPTH];
  logic [2:0]    stk_inm [DEPTH];
  logic          stk_ie  [DEPTH];

  assign idle     = (state == S_IDLE);
  assign req      = idle & bus.in_boundary & bus.in_break & ie_q &
                    (bus.in_code != 2'b00) & ~bus.in_eret;
  assign ovf      = req & (level == LVL_MAX);
  assign take     = req & ~ovf;
  assign eret     = idle & bus.in_boundary & bus.in_eret;
  assign eret_ok  = eret & (level != 2'd0);
  assign eret_bad = eret & (level == 2'd0);
  assign sw_ok    = idle & ~take & ~eret;
  assign top      = level - 2'd1;

  // Entering code N masks N and everything below it.
  assign code_mask = {code_q == 2'd3, code_q[1], 1'b1};
  assign vec_pc    = VEC_BASE + (AW'(code_q) << VEC_SHIFT);

  always_comb begin
    ig_dec = 4'b0000;
    case (code_q)
      2'd1:    ig_dec = 4'b0001;
      2'd2:    ig_dec = 4'b0010;
      2'd3:    ig_dec = 4'b0100;
      default: ig_dec = 4'b0000;
    endcase
  end

  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      state  <= S_IDLE;
      code_q <= 2'd0;
      pc_q   <= '0;
      level  <= 2'd0;
      ie_q   <= 1'b0;
      inm_q  <= 3'b000;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            code_q <= bus.in_code;
            pc_q   <= bus.in_PC;
            state  <= S_ACK;
          end else if (eret_ok) begin
            state  <= S_RET;
          end
          if (ovf | eret_bad) err_q <= 1'b1;
          if (sw_ok) begin
            if (bus.in_ie_we)  ie_q  <= bus.in_ie_data;
            if (bus.in_inm_we) inm_q <= bus.in_inm_data;
          end
        end
        S_ACK: begin
          level <= level + 2'd1;
          ie_q  <= 1'b0;
          state <= S_VECTOR;
        end
        S_VECTOR: begin
          inm_q <= inm_q | code_mask;
          ie_q  <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          inm_q <= stk_inm[top];
          ie_q  <= stk_ie[top];
          level <= top;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stack storage carries no reset; occupancy is tracked by level alone.
  always_ff @(posedge in_CLK) begin
    if (state == S_ACK) begin
      stk_pc[level]  <= pc_q;
      stk_inm[level] <= inm_q;
      stk_ie[level]  <= ie_q;
    end
  end

  assign bus.out_IE      = ie_q;
  assign bus.out_INM     = {1'b1, inm_q};
  assign bus.out_IG      = (state == S_ACK) ? ig_dec : 4'b0000;
  assign bus.out_stall   = take | eret | ~idle;
  assign bus.out_pc_load = (state == S_VECTOR) | (state == S_RET);
  assign bus.out_pc      = (state == S_VECTOR) ? vec_pc :
                           (state == S_RET)    ? stk_pc[top] : '0;
  assign bus.out_level   = level;
  assign bus.out_err     = err_q;
endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboarded bench for int_sequencer: directed entry/return/nesting/error/reset-abort vectors.
module tb_int_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_sequencer_if #(.AW(32)) bus ();

  int_sequencer #(
    .AW(32), .VEC_BASE(32'h0000_0100), .VEC_SHIFT(4), .DEPTH(3)
  ) dut (
    .in_CLK(clk),
    .in_RST(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  inm;
    logic        ie;
    logic [1:0]  lvl;
  } exp_t;

  exp_t       pcq [$];
  logic [3:0] igq [$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Redirect monitor: PC at the strobe, restored/updated state one cycle later.
  initial begin : pc_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_pc_load) begin
        if (pcq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pc_load: got pc 0x%0h, want no redirect", bus.out_pc);
        end else begin
          e = pcq.pop_front();
          chk("redirect_pc", bus.out_pc, e.pc);
          @(negedge clk);
          chk("post_inm", 32'(bus.out_INM), 32'(e.inm));
          chk("post_ie", 32'(bus.out_IE), 32'(e.ie));
          chk("post_level", 32'(bus.out_level), 32'(e.lvl));
        end
      end
    end
  end

  initial begin : ig_mon
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (bus.out_IG != 4'b0000) begin
        if (igq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ig: got 0x%0h, want 0x0", bus.out_IG);
        end else begin
          e = igq.pop_front();
          chk("ig_pulse", 32'(bus.out_IG), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.in_break    = 1'b0;
    bus.in_code     = 2'b00;
    bus.in_boundary = 1'b0;
    bus.in_PC       = 32'h0;
    bus.in_eret     = 1'b0;
    bus.in_ie_we    = 1'b0;
    bus.in_ie_data  = 1'b0;
    bus.in_inm_we   = 1'b0;
    bus.in_inm_data = 3'b000;
  endtask

  task automatic check_reset_vals();
    chk("rst_ie", 32'(bus.out_IE), 32'd0);
    chk("rst_inm", 32'(bus.out_INM), 32'h8);
    chk("rst_ig", 32'(bus.out_IG), 32'd0);
    chk("rst_pc_load", 32'(bus.out_pc_load), 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_level", 32'(bus.out_level), 32'd0);
    chk("rst_err", 32'(bus.out_err), 32'd0);
    chk("rst_stall", 32'(bus.out_stall), 32'd0);
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    #2 check_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic sw_write(input logic ie_we, input logic ie_d, input logic inm_we,
                          input logic [2:0] inm_d);
    bus.in_ie_we    = ie_we;
    bus.in_ie_data  = ie_d;
    bus.in_inm_we   = inm_we;
    bus.in_inm_data = inm_d;
    tick();
    quiet();
  endtask

  // Drives T0, then scrambles in_code/in_PC to show they are only sampled at take.
  task automatic take(input logic [1:0] code, input logic [31:0] pc);
    bus.in_boundary = 1'b1;
    bus.in_break    = 1'b1;
    bus.in_code     = code;
    bus.in_PC       = pc;
    #2 chk("stall_t0", 32'(bus.out_stall), 32'd1);
    tick();
    quiet();
    bus.in_code = ~code;
    bus.in_PC   = 32'hdead_beef;
    #2 chk("stall_t1", 32'(bus.out_stall), 32'd1);
    tick();
    #2 chk("stall_t2", 32'(bus.out_stall), 32'd1);
    tick();
    quiet();
    #2 chk("stall_t3", 32'(bus.out_stall), 32'd0);
  endtask

  task automatic eret();
    bus.in_boundary = 1'b1;
    bus.in_eret     = 1'b1;
    #2 chk("stall_eret", 32'(bus.out_stall), 32'd1);
    tick();
    quiet();
    #2 chk("stall_ret", 32'(bus.out_stall), 32'd1);
    tick();
    #2 chk("stall_after_ret", 32'(bus.out_stall), 32'd0);
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    #12 check_reset_vals();
    rst_n = 1'b1;
    tick();
    sw_write(1'b1, 1'b1, 1'b1, 3'b000);
    chk("sw_ie", 32'(bus.out_IE), 32'd1);
    chk("sw_inm", 32'(bus.out_INM), 32'h8);

    // Basic entry and return.
    igq.push_back(4'b0010);
    pcq.push_back('{32'h120, 4'b1011, 1'b1, 2'd1});
    take(2'd2, 32'h40);
    pcq.push_back('{32'h40, 4'b1000, 1'b1, 2'd0});
    eret();

    // Nesting: code 1 handler interrupted by code 3.
    igq.push_back(4'b0001);
    pcq.push_back('{32'h110, 4'b1001, 1'b1, 2'd1});
    take(2'd1, 32'h200);
    igq.push_back(4'b0100);
    pcq.push_back('{32'h130, 4'b1111, 1'b1, 2'd2});
    take(2'd3, 32'h300);
    pcq.push_back('{32'h300, 4'b1001, 1'b1, 2'd1});
    eret();
    pcq.push_back('{32'h200, 4'b1000, 1'b1, 2'd0});
    eret();

    // ERET and break together: return wins, break taken at the next boundary.
    igq.push_back(4'b0001);
    pcq.push_back('{32'h110, 4'b1001, 1'b1, 2'd1});
    take(2'd1, 32'h500);
    pcq.push_back('{32'h500, 4'b1000, 1'b1, 2'd0});
    bus.in_boundary = 1'b1;
    bus.in_eret     = 1'b1;
    bus.in_break    = 1'b1;
    bus.in_code     = 2'd2;
    bus.in_PC       = 32'h600;
    #2 chk("stall_eret_vs_break", 32'(bus.out_stall), 32'd1);
    tick();
    bus.in_boundary = 1'b0;
    bus.in_eret     = 1'b0;
    tick();
    igq.push_back(4'b0010);
    pcq.push_back('{32'h120, 4'b1011, 1'b1, 2'd1});
    take(2'd2, 32'h600);
    pcq.push_back('{32'h600, 4'b1000, 1'b1, 2'd0});
    eret();

    // ERET with an empty stack.
    bus.in_boundary = 1'b1;
    bus.in_eret     = 1'b1;
    tick();
    quiet();
    #2 chk("underflow_err", 32'(bus.out_err), 32'd1);
    chk("underflow_level", 32'(bus.out_level), 32'd0);
    chk("underflow_stall", 32'(bus.out_stall), 32'd0);
    tick();

    // Overflow: three nested takes with the mask cleared by software, then a fourth.
    do_reset();
    sw_write(1'b1, 1'b1, 1'b1, 3'b000);
    for (int i = 1; i <= 3; i++) begin
      igq.push_back(4'b0001);
      pcq.push_back('{32'h110, 4'b1001, 1'b1, 2'(i)});
      take(2'd1, 32'(i * 16));
      sw_write(1'b0, 1'b0, 1'b1, 3'b000);
    end
    bus.in_boundary = 1'b1;
    bus.in_break    = 1'b1;
    bus.in_code     = 2'd1;
    bus.in_PC       = 32'h40;
    #2 chk("overflow_stall", 32'(bus.out_stall), 32'd0);
    tick();
    quiet();
    #2 chk("overflow_err", 32'(bus.out_err), 32'd1);
    chk("overflow_level", 32'(bus.out_level), 32'd3);
    chk("overflow_ig", 32'(bus.out_IG), 32'd0);
    tick();
    tick();

    // Reset dropped during the redirect cycle.
    do_reset();
    sw_write(1'b1, 1'b1, 1'b0, 3'b000);
    igq.push_back(4'b0010);
    bus.in_boundary = 1'b1;
    bus.in_break    = 1'b1;
    bus.in_code     = 2'd2;
    bus.in_PC       = 32'h80;
    tick();
    quiet();
    tick();
    rst_n = 1'b0;
    #1 check_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    #2 chk("abort_level", 32'(bus.out_level), 32'd0);
    chk("abort_pc_load", 32'(bus.out_pc_load), 32'd0);

    chk("pc_queue_drained", 32'(pcq.size()), 32'd0);
    chk("ig_queue_drained", 32'(igq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
